// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution sequencer: kernel defaults, FSM states,
// output-map sizing helpers.
package cnn_pkg;

  localparam int KX_DEF = 5;
  localparam int KY_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of valid (no padding) convolution outputs for one frame.
  function automatic int n_out(input int img_w, input int img_h, input int kx, input int ky);
    return (img_w - kx + 1) * (img_h - ky + 1);
  endfunction

  // Counter width for a range of n values; never below one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_xy_counter.sv
// Raster-order x/y counter: x wraps at W-1 and bumps y; last flags (W-1, H-1).
module cnn_xy_counter
  import cnn_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  output logic [cw(W)-1:0]  x,
  output logic [cw(H)-1:0]  y,
  output logic              last
);

  localparam int XW = cw(W);
  localparam int YW = cw(H);
  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/cnn_conv_seq.sv
// Frame sequencer for a streaming KXxKY convolution: counts raster pixels, flags
// complete windows, tags kernel results with output-map coordinates.
module cnn_conv_seq
  import cnn_pkg::*;
#(
  parameter int KX    = KX_DEF,
  parameter int KY    = KY_DEF,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic                          i_pix_valid,
  output logic                          o_ready,
  output logic                          o_win_valid,
  input  logic                          i_ker_valid,
  output logic                          o_res_valid,
  output logic [cw(IMG_W-KX+1)-1:0]     o_res_x,
  output logic [cw(IMG_H-KY+1)-1:0]     o_res_y,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int OW    = IMG_W - KX + 1;
  localparam int N_OUT = n_out(IMG_W, IMG_H, KX, KY);
  localparam int OH    = N_OUT / OW;
  localparam int CW    = cw(IMG_W);
  localparam int RW    = cw(IMG_H);
  localparam logic [CW-1:0] COL_MIN = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_MIN = RW'(KY - 1);

  state_e state, state_n;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              in_last;
  logic [cw(OW)-1:0] rx;
  logic [cw(OH)-1:0] ry;
  logic              res_last, res_full;
  logic              active, start_acc, pix_acc, ker_act, overrun, res_acc;

  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  assign start_acc = (state == ST_IDLE) && i_start;
  assign pix_acc   = (state == ST_RUN) && i_pix_valid;
  assign ker_act   = i_ker_valid && active;
  // res_full marks that all N_OUT results were taken; anything further is an overrun.
  assign overrun   = ker_act && res_full;
  assign res_acc   = ker_act && !res_full;

  cnn_xy_counter #(.W(IMG_W), .H(IMG_H)) u_pix_cnt (
    .clk(clk), .reset_n(reset_n), .clr(start_acc), .inc(pix_acc),
    .x(col), .y(row), .last(in_last)
  );

  cnn_xy_counter #(.W(OW), .H(OH)) u_res_cnt (
    .clk(clk), .reset_n(reset_n), .clr(start_acc), .inc(res_acc),
    .x(rx), .y(ry), .last(res_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (i_start) state_n = ST_RUN;
      ST_RUN:   if (pix_acc && in_last) state_n = ST_DRAIN;
      ST_DRAIN: if (res_full) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_win_valid <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_x     <= '0;
      o_res_y     <= '0;
      res_full    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_win_valid <= pix_acc && (col >= COL_MIN) && (row >= ROW_MIN);
      o_res_valid <= res_acc;
      if (res_acc) begin
        o_res_x <= rx;
        o_res_y <= ry;
      end
      if (start_acc)                res_full <= 1'b0;
      else if (res_acc && res_last) res_full <= 1'b1;
      // A stray result on the start cycle still counts as an error.
      if ((i_ker_valid && !active) || overrun) o_err <= 1'b1;
      else if (start_acc)                      o_err <= 1'b0;
    end
  end

  assign o_ready = (state == ST_RUN);
  assign o_busy  = active;
  assign o_done  = (state == ST_DONE);

endmodule
